// File: rtl/decode_stage.sv
// Decode stage: splits the fetch word into register ids, immediate and
// control fields, selects operands with a writeback bypass, detects the
// load-use hazard and registers everything into the ID/EX pipeline slot.
module decode_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  rf_read1_id,
  output logic [4:0]  rf_read2_id,
  input  logic [31:0] rf_read1_data,
  input  logic [31:0] rf_read2_data,
  input  logic        wb_write_en,
  input  logic [4:0]  wb_write_id,
  input  logic [31:0] wb_write_data,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs1_id,
  output logic [4:0]  id_ex_rs2_id,
  output logic [4:0]  id_ex_rd,
  output logic [6:0]  id_ex_opcode,
  output logic [2:0]  id_ex_funct3,
  output logic        id_ex_funct7b5,
  output logic        id_ex_illegal
);

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISCMEM  = 7'b0001111;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_rs1_used, w_rs2_used;
  logic        w_hazard;
  logic        w_transfer;
  logic [31:0] w_rs1_data, w_rs2_data;
  logic [31:0] w_imm;
  logic        w_illegal;

  logic        r_valid;
  logic [31:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]  r_rs1_id, r_rs2_id, r_rd;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic        r_funct7b5;
  logic        r_illegal;

  assign w_opcode    = if_instr[6:0];
  assign w_rd        = if_instr[11:7];
  assign w_rs1       = if_instr[19:15];
  assign w_rs2       = if_instr[24:20];
  assign rf_read1_id = w_rs1;
  assign rf_read2_id = w_rs2;

  assign w_rs1_used = (w_opcode != OP_LUI) && (w_opcode != OP_AUIPC) && (w_opcode != OP_JAL);
  assign w_rs2_used = (w_opcode == OP_BRANCH) || (w_opcode == OP_STORE) || (w_opcode == OP_OP);

  // A load still in EX cannot forward in time; stall any consumer of its rd.
  assign w_hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((w_rs1_used && (ex_rd == w_rs1)) || (w_rs2_used && (ex_rd == w_rs2)));

  // id_ready is forced low during reset so fetch never sees a phantom accept.
  assign id_ready   = reset_n && ex_ready && !w_hazard && !flush;
  assign w_transfer = if_valid && id_ready;

  // Operand select: x0 is hardwired, then same-cycle writeback, then the RF.
  always_comb begin
    w_rs1_data = rf_read1_data;
    w_rs2_data = rf_read2_data;
    if (w_rs1 == 5'd0)
      w_rs1_data = 32'd0;
    else if (wb_write_en && (wb_write_id == w_rs1))
      w_rs1_data = wb_write_data;
    if (w_rs2 == 5'd0)
      w_rs2_data = 32'd0;
    else if (wb_write_en && (wb_write_id == w_rs2))
      w_rs2_data = wb_write_data;
  end

  // Immediate formation and legality check by opcode.
  always_comb begin
    w_imm     = 32'd0;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM:
        w_imm = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE:
        w_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      OP_BRANCH:
        w_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                 if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {if_instr[31:12], 12'd0};
      OP_JAL:
        w_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                 if_instr[30:21], 1'b0};
      OP_OP, OP_MISCMEM:
        w_imm = 32'd0;
      default:
        w_illegal = 1'b1;
    endcase
  end

  // ID/EX register: flush kills, transfer loads, ex_ready without transfer
  // inserts a bubble (payload kept), ex_ready low holds everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_pc       <= 32'd0;
      r_rs1_data <= 32'd0;
      r_rs2_data <= 32'd0;
      r_imm      <= 32'd0;
      r_rs1_id   <= 5'd0;
      r_rs2_id   <= 5'd0;
      r_rd       <= 5'd0;
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_funct7b5 <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (ex_ready) begin
      r_valid <= w_transfer;
      if (w_transfer) begin
        r_pc       <= if_pc;
        r_rs1_data <= w_rs1_data;
        r_rs2_data <= w_rs2_data;
        r_imm      <= w_imm;
        r_rs1_id   <= w_rs1;
        r_rs2_id   <= w_rs2;
        r_rd       <= w_rd;
        r_opcode   <= w_opcode;
        r_funct3   <= if_instr[14:12];
        r_funct7b5 <= if_instr[30];
        r_illegal  <= w_illegal;
      end
    end
  end

  assign id_ex_valid    = r_valid;
  assign id_ex_pc       = r_pc;
  assign id_ex_rs1_data = r_rs1_data;
  assign id_ex_rs2_data = r_rs2_data;
  assign id_ex_imm      = r_imm;
  assign id_ex_rs1_id   = r_rs1_id;
  assign id_ex_rs2_id   = r_rs2_id;
  assign id_ex_rd       = r_rd;
  assign id_ex_opcode   = r_opcode;
  assign id_ex_funct3   = r_funct3;
  assign id_ex_funct7b5 = r_funct7b5;
  assign id_ex_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_ready;
  logic [4:0]  rf_read1_id, rf_read2_id;
  logic [31:0] rf_read1_data, rf_read2_data;
  logic        wb_write_en;
  logic [4:0]  wb_write_id;
  logic [31:0] wb_write_data;
  logic        ex_valid, ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_ready, flush;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1_id, id_ex_rs2_id, id_ex_rd;
  logic [6:0]  id_ex_opcode;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5, id_ex_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset_n(reset_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready),
    .rf_read1_id(rf_read1_id), .rf_read2_id(rf_read2_id),
    .rf_read1_data(rf_read1_data), .rf_read2_data(rf_read2_data),
    .wb_write_en(wb_write_en), .wb_write_id(wb_write_id), .wb_write_data(wb_write_data),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_ready(ex_ready), .flush(flush),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs1_id(id_ex_rs1_id), .id_ex_rs2_id(id_ex_rs2_id),
    .id_ex_rd(id_ex_rd), .id_ex_opcode(id_ex_opcode), .id_ex_funct3(id_ex_funct3),
    .id_ex_funct7b5(id_ex_funct7b5), .id_ex_illegal(id_ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    rf_read1_data = 32'd0; rf_read2_data = 32'd0;
    wb_write_en = 1'b0; wb_write_id = 5'd0; wb_write_data = 32'd0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_ready = 1'b1; flush = 1'b0;

    // Reset state: outputs cleared and id_ready held low despite ex_ready=1
    #12;
    chk("rst_valid", id_ex_valid, 0);
    chk("rst_ready", id_ready, 0);
    chk("rst_pc", id_ex_pc, 0);
    reset_n = 1'b1;
    step();

    // addi x1,x0,5 at 0x100; rf data nonzero to prove x0 forcing
    if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100; rf_read1_data = 32'hAAAA;
    #1;
    chk("addi_ready", id_ready, 1);
    chk("addi_rf1id", rf_read1_id, 0);
    step();
    chk("addi_valid", id_ex_valid, 1);
    chk("addi_rd", id_ex_rd, 1);
    chk("addi_imm", id_ex_imm, 5);
    chk("addi_rs1d", id_ex_rs1_data, 0);
    chk("addi_pc", id_ex_pc, 32'h100);
    chk("addi_op", id_ex_opcode, 7'h13);
    chk("addi_ill", id_ex_illegal, 0);

    // Load-use: lw x5 in EX, add x6,x5,x7 in decode
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
    if_instr = 32'h00728333; if_pc = 32'h104;
    rf_read1_data = 32'h11; rf_read2_data = 32'h22;
    #1;
    chk("lu_ready0", id_ready, 0);
    step();
    chk("lu_bubble", id_ex_valid, 0);
    ex_valid = 1'b0;
    #1;
    chk("lu_ready1", id_ready, 1);
    step();
    chk("lu_valid", id_ex_valid, 1);
    chk("lu_rd", id_ex_rd, 6);
    chk("lu_rs1id", id_ex_rs1_id, 5);
    chk("lu_rs2id", id_ex_rs2_id, 7);
    chk("lu_rs1d", id_ex_rs1_data, 32'h11);
    chk("lu_rs2d", id_ex_rs2_data, 32'h22);
    chk("lu_pc", id_ex_pc, 32'h104);

    // addi x1,x0,7: bits[24:20]=7 match a load rd but rs2 is unused -> no hazard
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
    if_instr = 32'h00700093;
    #1;
    chk("nors2_ready", id_ready, 1);
    step();
    chk("nors2_imm", id_ex_imm, 7);
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;

    // Write-through bypass: add x4,x3,x0
    wb_write_en = 1'b1; wb_write_id = 5'd3; wb_write_data = 32'hDEADBEEF;
    rf_read1_data = 32'h0; rf_read2_data = 32'h55;
    if_instr = 32'h00018233;
    step();
    chk("byp_rs1d", id_ex_rs1_data, 32'hDEADBEEF);
    chk("byp_rs2d", id_ex_rs2_data, 0);
    chk("byp_rd", id_ex_rd, 4);

    // Writeback to x0 must not leak into an x0 operand
    wb_write_id = 5'd0; wb_write_data = 32'h1234; rf_read1_data = 32'h99;
    if_instr = 32'h00500093;
    step();
    chk("x0_rs1d", id_ex_rs1_data, 0);
    wb_write_en = 1'b0;

    // sw x2,-4(x1)
    if_instr = 32'hFE20AE23;
    step();
    chk("sw_imm", id_ex_imm, 32'hFFFFFFFC);
    chk("sw_f3", id_ex_funct3, 2);

    // beq x1,x2,-8
    if_instr = 32'hFE208CE3;
    step();
    chk("beq_imm", id_ex_imm, 32'hFFFFFFF8);

    // jal x1,+8
    if_instr = 32'h008000EF;
    step();
    chk("jal_imm", id_ex_imm, 8);

    // lui x5,0x12345
    if_instr = 32'h123452B7;
    step();
    chk("lui_imm", id_ex_imm, 32'h12345000);
    chk("lui_rd", id_ex_rd, 5);

    // EX stalls for 3 cycles: everything holds, id_ready low
    ex_ready = 1'b0; if_instr = 32'h00500093; if_pc = 32'h200;
    #1;
    chk("hold_ready", id_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", id_ex_valid, 1);
      chk("hold_imm", id_ex_imm, 32'h12345000);
      chk("hold_rd", id_ex_rd, 5);
      chk("hold_ready2", id_ready, 0);
    end

    // Flush kills the held entry even with ex_ready low
    flush = 1'b1;
    step();
    chk("flush_valid", id_ex_valid, 0);

    // Flush with a valid fetch word and ex_ready high: no acceptance
    ex_ready = 1'b1;
    #1;
    chk("flush_ready", id_ready, 0);
    step();
    chk("flush_valid2", id_ex_valid, 0);
    flush = 1'b0;

    // Illegal opcode still transfers
    if_instr = 32'h0000007F; if_pc = 32'h300;
    step();
    chk("ill_valid", id_ex_valid, 1);
    chk("ill_flag", id_ex_illegal, 1);
    chk("ill_imm", id_ex_imm, 0);

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", id_ex_valid, 0);
    chk("arst_ill", id_ex_illegal, 0);
    chk("arst_pc", id_ex_pc, 0);
    chk("arst_ready", id_ready, 0);
    if_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("post_valid", id_ex_valid, 0);
    chk("post_ready", id_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
